// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and register file.
// Optional retire counter is enabled by defining WRITEBACK_RETIRE_COUNT_EN.
package wb_pkg;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam int unsigned NREGS_DEFAULT       = 32;
  localparam int unsigned ADDR_W_DEFAULT      = 5;
  localparam int unsigned CTRL_W              = 4;
  localparam int unsigned RESULT_SRC_W        = 3;
  localparam int unsigned CTRL_REG_WRITE_BIT  = 3;
  localparam int unsigned CTRL_RESULT_SRC_LSB = 0;
  localparam int unsigned RETIRE_W            = 64;

  typedef enum logic [RESULT_SRC_W-1:0] {
    RS_ALU   = 3'd0,
    RS_RAM   = 3'd1,
    RS_PC4   = 3'd2,
    RS_IMM   = 3'd3,
    RS_PCIMM = 3'd4,
    RS_LT    = 3'd5
  } result_src_e;

  // Codes 6 and 7 are reserved and never commit.
  function automatic logic src_is_valid(input logic [RESULT_SRC_W-1:0] src);
    return src <= RESULT_SRC_W'(RS_LT);
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: x0 hardwired to zero, one synchronous write port,
// two combinational read ports that bypass the same-cycle write.
module regfile_2r1w
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  // Entry 0 is cleared by reset and never written afterwards.
  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (wr_en && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
    end
    if (wr_en && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
    end
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result from MEM/WB fields, qualifies the commit and
// feeds the register file. Define WRITEBACK_RETIRE_COUNT_EN for the retire counter.
module writeback_regfile
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CTRL_W-1:0]   ctrl_signals_in,
  input  logic [XLEN-1:0]     lt_sgn_ext_in,
  input  logic [XLEN-1:0]     ram_output_in,
  input  logic [XLEN-1:0]     alu_result_in,
  input  logic [XLEN-1:0]     imm_in,
  input  logic [XLEN-1:0]     pcimm_in,
  input  logic [XLEN-1:0]     pc4_in,
  input  logic [ADDR_W-1:0]   reg_write_addr_in,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic [XLEN-1:0]     wb_result,
  output logic                wb_write_valid,
  output logic [RETIRE_W-1:0] retire_count
);

  if (ADDR_W != $clog2(NREGS)) begin : g_bad_addr_w
    $error("ADDR_W must equal clog2(NREGS)");
  end

  logic                    reg_write;
  logic [RESULT_SRC_W-1:0] result_src;

  assign reg_write  = ctrl_signals_in[CTRL_REG_WRITE_BIT];
  assign result_src = ctrl_signals_in[CTRL_RESULT_SRC_LSB +: RESULT_SRC_W];

  // Result select; reserved codes yield zero.
  always_comb begin
    wb_result = '0;
    case (result_src)
      RS_ALU:   wb_result = alu_result_in;
      RS_RAM:   wb_result = ram_output_in;
      RS_PC4:   wb_result = pc4_in;
      RS_IMM:   wb_result = imm_in;
      RS_PCIMM: wb_result = pcimm_in;
      RS_LT:    wb_result = lt_sgn_ext_in;
      default:  wb_result = '0;
    endcase
  end

  // enable gates stalled cycles so a held MEM/WB entry commits only once.
  assign wb_write_valid = enable && reg_write && (reg_write_addr_in != '0) &&
                          src_is_valid(result_src);

  regfile_2r1w #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wb_write_valid),
    .waddr_i  (reg_write_addr_in),
    .wdata_i  (wb_result),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

`ifdef WRITEBACK_RETIRE_COUNT_EN
  logic [RETIRE_W-1:0] retire_q;
  logic [RETIRE_W-1:0] retire_d;

  always_comb begin
    retire_d = retire_q;
    if (wb_write_valid) begin
      retire_d = retire_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule
